exception_ctrl: RTL
===================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 Parameter: MEM_WAIT_CYCLES, default 1, extra cycles between the vector read request and valid Mem_Data_Byte (range 0..7).
REQ-002 Parameter: VEC_BASE, default 8'd253, byte address of the first exception vector.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 Port: Opcode_Invalid  input  1  decoder flags an undefined opcode this cycle.
REQ-006 Port: Overflow  input  1  ALU signed overflow on an overflow-checked instruction.
REQ-007 Port: Div_Zero  input  1  divider detected a zero divisor.
REQ-008 Port: Return_EPC  input  1  return-from-exception instruction is decoded; restore PC from EPC.
REQ-009 Port: Mem_Data_Byte  input  8  low byte of memory read data (vector contents).
REQ-010 Port: Exc_Addr  output  8  byte address of the vector being read.
REQ-011 Port: Mem_Read  output  1  one-cycle vector read request.
REQ-012 Port: EPC_Write  output  1  load EPC with current PC-4 this cycle.
REQ-013 Port: PC_Write  output  1  load PC from the PC-source mux this cycle.
REQ-014 Port: PCSourceCtrl  output  2  PC-source select: 00 Exception_Destiny, 01 EPC, 10 ALU, 11 shifted target.
REQ-015 Port: Exception_Destiny  output  8  registered vector byte driving mux input 00.
REQ-016 Port: Exc_Cause  output  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 div-zero.
REQ-017 Port: Busy  output  1  high whenever state is not IDLE; main control stalls while high.

Function
REQ-018 States SHALL be IDLE, SAVE_EPC, MEM_REQ, MEM_WAIT, LOAD_VEC, JUMP, RET.
REQ-019 IDLE: any exception input high SHALL go to SAVE_EPC and latch Exc_Cause; Return_EPC alone SHALL go to RET; otherwise stay.
REQ-020 Cause priority SHALL be Opcode_Invalid > Overflow > Div_Zero; exceptions SHALL win over a simultaneous Return_EPC.
REQ-021 Exc_Addr SHALL be VEC_BASE + (Exc_Cause - 1) as 8-bit modulo-256 arithmetic: 253, 254, 255 by default.
REQ-022 SAVE_EPC: EPC_Write=1 for exactly one cycle, then MEM_REQ.
REQ-023 MEM_REQ: Mem_Read=1 for exactly one cycle with Exc_Addr valid; then MEM_WAIT, or LOAD_VEC if MEM_WAIT_CYCLES=0.
REQ-024 MEM_WAIT: a down-counter loaded with MEM_WAIT_CYCLES SHALL stay MEM_WAIT_CYCLES cycles, then LOAD_VEC.
REQ-025 LOAD_VEC: Exception_Destiny SHALL register Mem_Data_Byte at the end of the cycle, then JUMP.
REQ-026 JUMP: PCSourceCtrl=00, PC_Write=1 for one cycle, then IDLE.
REQ-027 RET: PCSourceCtrl=01, PC_Write=1 for one cycle, then IDLE; Exc_Cause SHALL clear to 00.
REQ-028 Exception latency: event in IDLE at cycle N gives PC_Write in JUMP at cycle N+4+MEM_WAIT_CYCLES.
REQ-029 Inputs SHALL be ignored while Busy; no event queuing.
REQ-030 Outside JUMP and RET: PCSourceCtrl=10, PC_Write=0.
REQ-031 Exception_Destiny and Exc_Cause SHALL hold their values until overwritten.

Reset
REQ-032 Reset SHALL force IDLE, with Busy, Mem_Read, EPC_Write and PC_Write at 0, PCSourceCtrl=10, Exc_Addr=0, Exception_Destiny=0, Exc_Cause=00 and wait counter=0.
REQ-033 Reset asserted in any state, including mid-sequence, SHALL abort the sequence with no further strobes; the first clock after deassertion SHALL evaluate IDLE.

Structure
REQ-034 State encoding, Exc_Cause codes and PCSourceCtrl codes SHALL live in the shared CPU control package, for use by the main control unit.
REQ-035 Single module; the wait counter SHALL be inline, with no sub-module.

Verification
REQ-036 Overflow=1 in IDLE, Mem_Data_Byte=8'h40 in LOAD_VEC -> EPC_Write at N+1, Mem_Read with Exc_Addr=254 at N+2, PC_Write with PCSourceCtrl=00 and Exception_Destiny=8'h40 at N+4+1.
REQ-037 Opcode_Invalid=Div_Zero=Return_EPC=1 together -> Exc_Cause=01, Exc_Addr=253, no RET state entered.
REQ-038 Return_EPC=1 in IDLE -> next cycle PC_Write=1 with PCSourceCtrl=01, Busy=1 for one cycle, then IDLE.
REQ-039 Div_Zero pulsed during MEM_WAIT of an opcode exception -> ignored: Exc_Cause stays 01 and exactly one PC_Write occurs.
REQ-040 Reset asserted in MEM_REQ -> same cycle Busy=0, Mem_Read=0, Exception_Destiny=0; no PC_Write after release.
REQ-041 MEM_WAIT_CYCLES=0 and MEM_WAIT_CYCLES=3 -> Div_Zero latency to PC_Write is 4 and 7 cycles respectively; Exc_Addr=255.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// ============================================================================
// Module   : exception_ctrl_pkg
// Brief    : Shared CPU control encodings for the exception controller and the
//            main control unit (FSM states, cause codes, PC-source codes).
// Revision : 1.0
// ============================================================================
`default_nettype none

package exception_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAVE_EPC = 3'd1,
    ST_MEM_REQ  = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_LOAD_VEC = 3'd4,
    ST_JUMP     = 3'd5,
    ST_RET      = 3'd6
  } exc_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_OPCODE   = 2'b01,
    CAUSE_OVERFLOW = 2'b10,
    CAUSE_DIV_ZERO = 2'b11
  } exc_cause_e;

  typedef enum logic [1:0] {
    PCSRC_EXC   = 2'b00,
    PCSRC_EPC   = 2'b01,
    PCSRC_ALU   = 2'b10,
    PCSRC_SHIFT = 2'b11
  } pc_src_e;

  // Vector table starts at base for cause 01; the sum wraps modulo 256.
  function automatic logic [7:0] vec_addr(input logic [7:0] base, input exc_cause_e cause);
    return base + {6'd0, cause} - 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exception_ctrl_if.sv
// ============================================================================
// Module   : exception_ctrl_if
// Brief    : Bundle between main control/datapath (master) and the exception
//            controller (slave).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface exception_ctrl_if;
  logic       Opcode_Invalid;
  logic       Overflow;
  logic       Div_Zero;
  logic       Return_EPC;
  logic [7:0] Mem_Data_Byte;
  logic [7:0] Exc_Addr;
  logic       Mem_Read;
  logic       EPC_Write;
  logic       PC_Write;
  logic [1:0] PCSourceCtrl;
  logic [7:0] Exception_Destiny;
  logic [1:0] Exc_Cause;
  logic       Busy;

  modport master (
    output Opcode_Invalid, Overflow, Div_Zero, Return_EPC, Mem_Data_Byte,
    input  Exc_Addr, Mem_Read, EPC_Write, PC_Write, PCSourceCtrl,
           Exception_Destiny, Exc_Cause, Busy
  );

  modport slave (
    input  Opcode_Invalid, Overflow, Div_Zero, Return_EPC, Mem_Data_Byte,
    output Exc_Addr, Mem_Read, EPC_Write, PC_Write, PCSourceCtrl,
           Exception_Destiny, Exc_Cause, Busy
  );
endinterface

`default_nettype wire

// File: rtl/exception_ctrl.sv
// ============================================================================
// Module   : exception_ctrl
// Brief    : Exception sequencer: saves EPC, fetches the vector byte, jumps to
//            it, and handles return-from-exception. All outputs registered.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exception_ctrl #(
  parameter int         MEM_WAIT_CYCLES = 1,
  parameter logic [7:0] VEC_BASE        = 8'd253
) (
  input  wire logic       clk,
  input  wire logic       reset,
  exception_ctrl_if.slave exc
);
  import exception_ctrl_pkg::*;

  localparam logic [2:0] c_wait_load = 3'(MEM_WAIT_CYCLES);
  localparam bit         c_skip_wait = (MEM_WAIT_CYCLES == 0);

  exc_state_e state_q, state_d;
  exc_cause_e cause_q, cause_d, w_cause;
  pc_src_e    pc_src_q, pc_src_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] exc_addr_q, exc_addr_d;
  logic [7:0] dest_q, dest_d;
  logic       mem_read_q, mem_read_d;
  logic       epc_write_q, epc_write_d;
  logic       pc_write_q, pc_write_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    wait_cnt_d = wait_cnt_q;
    exc_addr_d = exc_addr_q;
    dest_d     = dest_q;

    if (exc.Opcode_Invalid)  w_cause = CAUSE_OPCODE;
    else if (exc.Overflow)   w_cause = CAUSE_OVERFLOW;
    else if (exc.Div_Zero)   w_cause = CAUSE_DIV_ZERO;
    else                     w_cause = CAUSE_NONE;

    case (state_q)
      ST_IDLE: begin
        // Exceptions take precedence over a simultaneous return.
        if (w_cause != CAUSE_NONE) begin
          state_d    = ST_SAVE_EPC;
          cause_d    = w_cause;
          exc_addr_d = vec_addr(VEC_BASE, w_cause);
        end else if (exc.Return_EPC) begin
          state_d = ST_RET;
          cause_d = CAUSE_NONE;
        end
      end
      ST_SAVE_EPC: state_d = ST_MEM_REQ;
      ST_MEM_REQ: begin
        if (c_skip_wait) begin
          state_d = ST_LOAD_VEC;
        end else begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = c_wait_load;
        end
      end
      ST_MEM_WAIT: begin
        if (wait_cnt_q != 3'd0) wait_cnt_d = wait_cnt_q - 3'd1;
        if (wait_cnt_q <= 3'd1) state_d = ST_LOAD_VEC;
      end
      ST_LOAD_VEC: begin
        dest_d  = exc.Mem_Data_Byte;
        state_d = ST_JUMP;
      end
      ST_JUMP:  state_d = ST_IDLE;
      ST_RET:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they appear registered.
    epc_write_d = (state_d == ST_SAVE_EPC);
    mem_read_d  = (state_d == ST_MEM_REQ);
    pc_write_d  = (state_d == ST_JUMP) || (state_d == ST_RET);
    busy_d      = (state_d != ST_IDLE);
    if (state_d == ST_JUMP)     pc_src_d = PCSRC_EXC;
    else if (state_d == ST_RET) pc_src_d = PCSRC_EPC;
    else                        pc_src_d = PCSRC_ALU;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cause_q     <= CAUSE_NONE;
      pc_src_q    <= PCSRC_ALU;
      wait_cnt_q  <= 3'd0;
      exc_addr_q  <= 8'd0;
      dest_q      <= 8'd0;
      mem_read_q  <= 1'b0;
      epc_write_q <= 1'b0;
      pc_write_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      pc_src_q    <= pc_src_d;
      wait_cnt_q  <= wait_cnt_d;
      exc_addr_q  <= exc_addr_d;
      dest_q      <= dest_d;
      mem_read_q  <= mem_read_d;
      epc_write_q <= epc_write_d;
      pc_write_q  <= pc_write_d;
      busy_q      <= busy_d;
    end
  end

  assign exc.Exc_Addr          = exc_addr_q;
  assign exc.Mem_Read          = mem_read_q;
  assign exc.EPC_Write         = epc_write_q;
  assign exc.PC_Write          = pc_write_q;
  assign exc.PCSourceCtrl      = pc_src_q;
  assign exc.Exception_Destiny = dest_q;
  assign exc.Exc_Cause         = cause_q;
  assign exc.Busy              = busy_q;

endmodule

`default_nettype wire
